// File: rtl/gp_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gp_input_conditioner
// Brief    : Two-flop synchronizer, per-bit debounce and registered edge
//            pulses for raw general-purpose inputs feeding the GP input PIO.
//            Optional sticky rising-edge capture with a masked interrupt is
//            built only when the macro GP_EDGE_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gp_input_conditioner #(
  parameter int               WIDTH           = 8,
  // Legal range 1 .. 2**CNT_W-1
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] raw_in_i,
`ifdef GP_EDGE_IRQ_EN
  input  logic [WIDTH-1:0] clear_mask_i,
  input  logic [WIDTH-1:0] irq_mask_i,
  output logic [WIDTH-1:0] edge_capture_o,
  output logic             irq_o,
`endif
  output logic [WIDTH-1:0] data_out_o,
  output logic [WIDTH-1:0] rise_pulse_o,
  output logic [WIDTH-1:0] fall_pulse_o,
  output logic             changed_o
);

  // Count value at which a differing level has persisted DEBOUNCE_CYCLES edges
  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s0_q;
  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            data_q;
  logic [WIDTH-1:0]            rise_q;
  logic [WIDTH-1:0]            fall_q;
  logic                        changed_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            accept_d;
  logic [WIDTH-1:0]            data_d;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_d;

  // Per-bit debounce decision; every bit is evaluated independently.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_diff;
    logic w_at_term;

    assign w_diff      = s1_q[i] ^ data_q[i];
    assign w_at_term   = (cnt_q[i] == c_TERM);
    assign accept_d[i] = w_diff & w_at_term;
    // A return to the accepted level, an acceptance, or any out-of-range
    // count all reload to zero, so the counter can never wrap.
    assign cnt_d[i]    = (!w_diff || (cnt_q[i] >= c_TERM)) ? '0
                                                            : cnt_q[i] + 1'b1;
  end

  // Accepted bits take the synchronized level; others hold.
  assign data_d = (data_q & ~accept_d) | (s1_q & accept_d);
  assign rise_d = accept_d & s1_q;
  assign fall_d = accept_d & ~s1_q;

  // Synchronizer, debounce state and edge pulses share one register stage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s0_q      <= RESET_VALUE;
      s1_q      <= RESET_VALUE;
      data_q    <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s0_q      <= raw_in_i;
      s1_q      <= s0_q;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= |accept_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out_o   = data_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign changed_o    = changed_q;

`ifdef GP_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_q;
  logic             irq_q;

  // Sticky rising-edge flags; a coincident set overrides the clear strobe,
  // and the interrupt is registered one cycle behind the flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clear_mask_i) | rise_q;
      irq_q  <= |(edge_q & irq_mask_i);
    end
  end

  assign edge_capture_o = edge_q;
  assign irq_o          = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gp_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp_input_conditioner
// Brief    : Self-checking bench for gp_input_conditioner. A per-edge vector
//            table drives the main DEBOUNCE_CYCLES=4 instance; hand sequences
//            cover reset mid-count, the DEBOUNCE_CYCLES=1 case and, when
//            GP_EDGE_IRQ_EN is defined, the edge-capture/interrupt path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp_input_conditioner;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] data;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_in;
  logic [7:0] data_out, rise_p, fall_p;
  logic       changed;
  logic [7:0] raw1;
  logic [7:0] data1, rise1, fall1;
  logic       changed1;
`ifdef GP_EDGE_IRQ_EN
  logic [7:0] clear_mask, irq_mask, edge_cap, clear1, irqm1, edge_cap1;
  logic       irq, irq1;
`endif

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  gp_input_conditioner #(
    .WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(16), .RESET_VALUE(8'h00)
  ) u_dut (
    .clk_i(clk), .reset_i(rst), .raw_in_i(raw_in),
`ifdef GP_EDGE_IRQ_EN
    .clear_mask_i(clear_mask), .irq_mask_i(irq_mask),
    .edge_capture_o(edge_cap), .irq_o(irq),
`endif
    .data_out_o(data_out), .rise_pulse_o(rise_p),
    .fall_pulse_o(fall_p), .changed_o(changed)
  );

  gp_input_conditioner #(
    .WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_W(16), .RESET_VALUE(8'h00)
  ) u_dut1 (
    .clk_i(clk), .reset_i(rst), .raw_in_i(raw1),
`ifdef GP_EDGE_IRQ_EN
    .clear_mask_i(clear1), .irq_mask_i(irqm1),
    .edge_capture_o(edge_cap1), .irq_o(irq1),
`endif
    .data_out_o(data1), .rise_pulse_o(rise1),
    .fall_pulse_o(fall1), .changed_o(changed1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] raw, input logic [7:0] data,
                     input logic [7:0] rise, input logic [7:0] fall, input logic chg);
    vec_t v;
    v.raw = raw; v.data = data; v.rise = rise; v.fall = fall; v.chg = chg;
    tbl.push_back(v);
  endtask

  // A steady new level: 5 quiet edges, accept on edge 6, pulses gone on edge 7.
  task automatic add_change(input logic [7:0] raw, input logic [7:0] old_d,
                            input logic [7:0] new_d, input logic [7:0] rise,
                            input logic [7:0] fall);
    for (int k = 0; k < 5; k++) add(raw, old_d, 8'h00, 8'h00, 1'b0);
    add(raw, new_d, rise, fall, 1'b1);
    add(raw, new_d, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic chk_main(input string tag, input logic [7:0] d, input logic [7:0] r,
                          input logic [7:0] f, input logic c);
    chk({tag, " data"}, data_out, d);
    chk({tag, " rise"}, rise_p, r);
    chk({tag, " fall"}, fall_p, f);
    chk({tag, " chg"}, {7'd0, changed}, {7'd0, c});
  endtask

  initial begin
    // Release from reset with all pins high: accepted 6 edges later.
    add_change(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
    // Bit 0 low for only 3 cycles: rejected.
    for (int k = 0; k < 3; k++) add(8'hFE, 8'hFF, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) add(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    // Bit 3 falls.
    add_change(8'hF7, 8'hFF, 8'hF7, 8'h00, 8'h08);
    // Bits 1 and 7 fall together, then rise together.
    add_change(8'h75, 8'hF7, 8'h75, 8'h00, 8'h82);
    add_change(8'hF7, 8'h75, 8'hF7, 8'h82, 8'h00);
    // Bit 2 falls, bit 5 falls two cycles later: independent acceptance.
    add(8'hF3, 8'hF7, 8'h00, 8'h00, 1'b0);
    add(8'hF3, 8'hF7, 8'h00, 8'h00, 1'b0);
    add(8'hD3, 8'hF7, 8'h00, 8'h00, 1'b0);
    add(8'hD3, 8'hF7, 8'h00, 8'h00, 1'b0);
    add(8'hD3, 8'hF7, 8'h00, 8'h00, 1'b0);
    add(8'hD3, 8'hF3, 8'h00, 8'h04, 1'b1);
    add(8'hD3, 8'hF3, 8'h00, 8'h00, 1'b0);
    add(8'hD3, 8'hD3, 8'h00, 8'h20, 1'b1);
    add(8'hD3, 8'hD3, 8'h00, 8'h00, 1'b0);

    rst    = 1'b1;
    raw_in = 8'hFF;
    raw1   = 8'h00;
`ifdef GP_EDGE_IRQ_EN
    clear_mask = 8'h00; irq_mask = 8'h01; clear1 = 8'h00; irqm1 = 8'h00;
`endif
    tick();
    tick();
    chk_main("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      raw_in = tbl[i].raw;
      tick();
      chk_main($sformatf("row%0d", i), tbl[i].data, tbl[i].rise, tbl[i].fall, tbl[i].chg);
    end

    // Reset asserted at count 2 of 4 (bits 2,3,5 rising).
    raw_in = 8'hFF;
    for (int k = 0; k < 4; k++) tick();
    chk_main("precount", 8'hD3, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk_main("midreset", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_main($sformatf("postrst%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    chk_main("postrst6", 8'hFF, 8'hFF, 8'h00, 1'b1);
    tick();
    chk_main("postrst7", 8'hFF, 8'h00, 8'h00, 1'b0);

    // DEBOUNCE_CYCLES=1: synchronizer plus one cycle, single-cycle pulses pass.
    raw1 = 8'h01;
    tick();
    tick();
    chk("d1 edge2 data", data1, 8'h00);
    tick();
    chk("d1 edge3 data", data1, 8'h01);
    chk("d1 edge3 rise", rise1, 8'h01);
    raw1 = 8'h00;
    tick();
    raw1 = 8'h01;
    tick();
    chk("d1 glitch pre", data1, 8'h01);
    tick();
    chk("d1 glitch data", data1, 8'h00);
    chk("d1 glitch fall", fall1, 8'h01);
    tick();
    chk("d1 back data", data1, 8'h01);
    chk("d1 back rise", rise1, 8'h01);
    chk("d1 back chg", {7'd0, changed1}, 8'h01);

`ifdef GP_EDGE_IRQ_EN
    clear_mask = 8'hFF;
    tick();
    chk("cap cleared", edge_cap, 8'h00);
    clear_mask = 8'h00;
    tick();
    chk("irq idle", {7'd0, irq}, 8'h00);
    raw_in = 8'hFE;
    for (int k = 0; k < 7; k++) tick();
    raw_in = 8'hFF;
    for (int k = 0; k < 6; k++) tick();
    chk("irq rise0", rise_p, 8'h01);
    tick();
    chk("cap set", edge_cap, 8'h01);
    chk("irq lag", {7'd0, irq}, 8'h00);
    tick();
    chk("irq set", {7'd0, irq}, 8'h01);
    raw_in = 8'hFE;
    for (int k = 0; k < 7; k++) tick();
    raw_in = 8'hFF;
    for (int k = 0; k < 6; k++) tick();
    chk("irq rise0b", rise_p, 8'h01);
    clear_mask = 8'h01;
    tick();
    chk("set wins", edge_cap, 8'h01);
    clear_mask = 8'h00;
    tick();
    chk("irq held", {7'd0, irq}, 8'h01);
    clear_mask = 8'h01;
    tick();
    chk("lone clear", edge_cap, 8'h00);
    chk("irq still", {7'd0, irq}, 8'h01);
    clear_mask = 8'h00;
    tick();
    chk("irq drop", {7'd0, irq}, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
